// File: rtl/phase_pkg.sv
// Shared beat-bus definitions for the timing generator and its consumers.
// Beat constants are one-hot; next_beat() rotates P0->P1->P2->P3->P0.
package phase_pkg;

  localparam logic [3:0] P0 = 4'b0001;
  localparam logic [3:0] P1 = 4'b0010;
  localparam logic [3:0] P2 = 4'b0100;
  localparam logic [3:0] P3 = 4'b1000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    RUN  = 3'd2,
    HALT = 3'd3,
    ERR  = 3'd4
  } state_t;

  function automatic logic [3:0] next_beat(input logic [3:0] beat);
    return {beat[2:0], beat[3]};
  endfunction

endpackage

// File: rtl/phase_ctrl_seq_beat_checker.sv
// beat_checker: tracks the expected beat and classifies the incoming one (match / zero / index).
// Combinational outputs, tracker updates on clk; PHASE_CHECK_EN selects tracking vs. direct priority decode.
module beat_checker
  import phase_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] t,
  input  logic       clr,
  input  logic       sync,
  input  logic       step,
  output logic       match,
  output logic       is_zero,
  output logic [1:0] idx
);

  assign is_zero = (t == 4'b0000);

  // Highest set bit wins, so a malformed beat still yields a defined index.
  always_comb begin
    if (t[3])      idx = 2'd3;
    else if (t[2]) idx = 2'd2;
    else if (t[1]) idx = 2'd1;
    else           idx = 2'd0;
  end

`ifdef PHASE_CHECK_EN
  logic [3:0] expected;

  always_ff @(posedge clk) begin
    if (rst || clr)
      expected <= P0;
    else if (sync)
      expected <= next_beat(P0);
    else if (step)
      expected <= next_beat(expected);
  end

  // expected is always one-hot, so equality also rejects multi-bit beats.
  assign match = (t == expected);
`else
  logic unused_ctl;
  assign unused_ctl = ^{clk, rst, clr, sync, step};
  assign match      = !is_zero;
`endif

endmodule

// File: rtl/phase_ctrl_seq.sv
// phase_ctrl_seq: consumes the one-hot beat bus and issues registered per-phase micro-op strobes.
// Latency 1 clk beat->strobe, no backpressure; PHASE_CHECK_EN enables sequence checking and the ERR state.
module phase_ctrl_seq
  import phase_pkg::*;
#(
  parameter int ICNT_W      = 16,
  parameter int HALT_ON_ERR = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        t,
  input  logic              halt_req,
  output logic              fetch_en,
  output logic              pc_inc,
  output logic              decode_en,
  output logic              exec_en,
  output logic              wb_en,
  output logic              halted,
  output logic              seq_err,
  output logic [ICNT_W-1:0] icnt
);

  state_t     state;
  logic       match;
  logic       is_zero;
  logic       is_p0;
  logic [1:0] idx;
  logic       clr;
  logic       sync;
  logic       step;

  assign is_p0 = (t == P0);
  assign clr   = is_zero;
  // A P0 seen outside RUN/HALT starts an instruction, so the tracker jumps to P1.
  assign sync  = is_p0 && (state == IDLE || state == SYNC || state == ERR);
  assign step  = match && (state == RUN || state == HALT);

  beat_checker u_chk (
    .clk     (clk),
    .rst     (rst),
    .t       (t),
    .clr     (clr),
    .sync    (sync),
    .step    (step),
    .match   (match),
    .is_zero (is_zero),
    .idx     (idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      fetch_en  <= 1'b0;
      pc_inc    <= 1'b0;
      decode_en <= 1'b0;
      exec_en   <= 1'b0;
      wb_en     <= 1'b0;
      icnt      <= '0;
    end else begin
      fetch_en  <= 1'b0;
      pc_inc    <= 1'b0;
      decode_en <= 1'b0;
      exec_en   <= 1'b0;
      wb_en     <= 1'b0;
      case (state)
        // IDLE and SYNC share handling so a P0 arriving straight out of IDLE is not lost.
        IDLE, SYNC: begin
          if (is_zero) begin
            state <= IDLE;
          end else if (is_p0) begin
            state    <= RUN;
            fetch_en <= 1'b1;
            pc_inc   <= 1'b1;
          end else begin
            state <= SYNC;
          end
        end
        RUN: begin
          if (is_zero) begin
            state <= IDLE;
          end else if (match) begin
            case (idx)
              2'd0: begin
                fetch_en <= 1'b1;
                pc_inc   <= 1'b1;
              end
              2'd1: decode_en <= 1'b1;
              2'd2: exec_en   <= 1'b1;
              2'd3: begin
                wb_en <= 1'b1;
                icnt  <= icnt + ICNT_W'(1);
                if (halt_req)
                  state <= HALT;
              end
              default: ;
            endcase
          end else begin
`ifdef PHASE_CHECK_EN
            state <= ERR;
`endif
          end
        end
        HALT: begin
          // Leaving on P3 means the next beat is a clean P0.
          if (is_zero) begin
            state <= IDLE;
          end else if (match) begin
            if (idx == 2'd3 && !halt_req)
              state <= RUN;
          end else begin
`ifdef PHASE_CHECK_EN
            state <= ERR;
`endif
          end
        end
`ifdef PHASE_CHECK_EN
        ERR: begin
          if (HALT_ON_ERR == 0 && is_p0) begin
            state    <= RUN;
            fetch_en <= 1'b1;
            pc_inc   <= 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign halted = (state == HALT);

`ifdef PHASE_CHECK_EN
  assign seq_err = (state == ERR);
`else
  localparam int unused_hoe = HALT_ON_ERR;
  assign seq_err = 1'b0;
`endif

endmodule
